// File: rtl/stopwatch_key_ctrl_if.sv
// rtl/stopwatch_key_ctrl_if.sv - key inputs and conditioned outputs of the stopwatch key front-end
interface stopwatch_key_ctrl_if;
  logic inClr;
  logic inPause;
  logic clr;
  logic clr_pulse;
  logic pause_pulse;
  logic pause;

  // Board/bench side: drives raw keys, observes conditioned outputs
  modport master (
    output inClr,
    output inPause,
    input  clr,
    input  clr_pulse,
    input  pause_pulse,
    input  pause
  );

  // Key conditioner side
  modport slave (
    input  inClr,
    input  inPause,
    output clr,
    output clr_pulse,
    output pause_pulse,
    output pause
  );
endinterface

// File: rtl/stopwatch_key_ctrl.sv
// rtl/stopwatch_key_ctrl.sv - key sync, tick debounce, press-edge detect and RUN/STOP toggle
module stopwatch_key_ctrl #(
  parameter int TICK_DIV       = 500000,
  parameter int STABLE_TICKS   = 2,
  parameter int KEY_ACTIVE_LOW = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  stopwatch_key_ctrl_if.slave  key_if
);

  localparam int              PW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int              CW        = $clog2(STABLE_TICKS) + 1;
  localparam logic [PW-1:0]   TICK_LAST = PW'(TICK_DIV - 1);
  localparam logic [CW-1:0]   CNT_LAST  = CW'(STABLE_TICKS - 1);
  // Raw level of a released key; sync flops reset to it so reset never looks like a press
  localparam logic            KEY_IDLE  = (KEY_ACTIVE_LOW != 0);

  typedef enum logic {ST_STOP, ST_RUN} state_t;

  // Index 0 is the clear key, index 1 the pause key
  logic [PW-1:0] r_presc;
  logic          w_tick;
  logic [1:0]    w_raw;
  logic [1:0]    r_sync1;
  logic [1:0]    r_sync2;
  logic [1:0]    w_act;
  logic [1:0]    r_db;
  logic [CW-1:0] r_cnt [2];
  logic [1:0]    r_db_d;
  logic [1:0]    r_pulse;
  logic          r_clr;
  logic          r_pause;
  state_t        r_state;

  assign w_raw  = {key_if.inPause, key_if.inClr};
  assign w_tick = (r_presc == TICK_LAST);
  assign w_act  = KEY_IDLE ? ~r_sync2 : r_sync2;

  // Free-running prescaler producing one debounce sample tick per TICK_DIV clocks
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_presc <= '0;
    end else if (w_tick) begin
      r_presc <= '0;
    end else begin
      r_presc <= r_presc + PW'(1);
    end
  end

  // Two-flop synchronisers for the asynchronous raw keys
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_sync1 <= {2{KEY_IDLE}};
      r_sync2 <= {2{KEY_IDLE}};
    end else begin
      r_sync1 <= w_raw;
      r_sync2 <= r_sync1;
    end
  end

  // Debounce: accept a new level only after STABLE_TICKS consecutive differing ticks
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_db  <= '0;
      r_cnt <= '{default: '0};
    end else if (w_tick) begin
      for (int k = 0; k < 2; k++) begin
        if (w_act[k] == r_db[k]) begin
          r_cnt[k] <= '0;
        end else if (r_cnt[k] == CNT_LAST) begin
          r_db[k]  <= w_act[k];
          r_cnt[k] <= '0;
        end else begin
          r_cnt[k] <= r_cnt[k] + CW'(1);
        end
      end
    end
  end

  // Registered press-edge detect and clear level, aligned to the same clock
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_db_d  <= '0;
      r_pulse <= '0;
      r_clr   <= 1'b0;
    end else begin
      r_db_d  <= r_db;
      r_pulse <= r_db & ~r_db_d;
      r_clr   <= r_db[0];
    end
  end

  // RUN/STOP toggle; a clear press always stops, even against a same-cycle pause press
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= ST_STOP;
      r_pause <= 1'b1;
    end else if (r_pulse[0]) begin
      r_state <= ST_STOP;
      r_pause <= 1'b1;
    end else if (r_pulse[1]) begin
      case (r_state)
        ST_STOP: begin
          r_state <= ST_RUN;
          r_pause <= 1'b0;
        end
        default: begin
          r_state <= ST_STOP;
          r_pause <= 1'b1;
        end
      endcase
    end
  end

  assign key_if.clr         = r_clr;
  assign key_if.clr_pulse   = r_pulse[0];
  assign key_if.pause_pulse = r_pulse[1];
  assign key_if.pause       = r_pause;

endmodule

// File: tb/tb_stopwatch_key_ctrl.sv
// tb/tb_stopwatch_key_ctrl.sv - directed table-driven bench for stopwatch_key_ctrl
module tb_stopwatch_key_ctrl;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  stopwatch_key_ctrl_if key_if ();

  stopwatch_key_ctrl #(
    .TICK_DIV       (4),
    .STABLE_TICKS   (3),
    .KEY_ACTIVE_LOW (1)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .key_if (key_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic clr_key;
    logic pause_key;
    int   cycles;
    int   exp_clr_pulses;
    int   exp_pause_pulses;
    int   exp_both;
    logic exp_clr;
    logic exp_pause;
    logic chk_cnt;
  } vec_t;

  vec_t vecs [14];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Drive pressed/released keys; raw keys are active-low
  task automatic drive_keys(input logic clr_key, input logic pause_key);
    key_if.inClr   = ~clr_key;
    key_if.inPause = ~pause_key;
  endtask

  initial begin
    logic prev_cp;
    logic prev_pp;
    int   cp_rise;
    int   pp_rise;
    int   cp_high;
    int   pp_high;
    int   both;
    int   pre_pulses;
    int   total_pulses;
    logic pulse13;
    logic pause13;
    logic pause14;
    logic pulse14;

    checks   = 0;
    failures = 0;
    prev_cp  = 1'b0;
    prev_pp  = 1'b0;

    //                clr pau cyc cp pp both clr pause cnt
    vecs[0]  = '{1'b0, 1'b0, 40, 0, 0, 0, 1'b0, 1'b1, 1'b0};
    vecs[1]  = '{1'b0, 1'b1,  8, 0, 0, 0, 1'b0, 1'b1, 1'b0};
    vecs[2]  = '{1'b0, 1'b0, 20, 0, 0, 0, 1'b0, 1'b1, 1'b1};
    vecs[3]  = '{1'b0, 1'b1, 20, 0, 1, 0, 1'b0, 1'b0, 1'b0};
    vecs[4]  = '{1'b0, 1'b0, 20, 0, 0, 0, 1'b0, 1'b0, 1'b1};
    vecs[5]  = '{1'b0, 1'b1, 20, 0, 1, 0, 1'b0, 1'b1, 1'b0};
    vecs[6]  = '{1'b0, 1'b0, 20, 0, 0, 0, 1'b0, 1'b1, 1'b0};
    vecs[7]  = '{1'b0, 1'b1, 20, 0, 1, 0, 1'b0, 1'b0, 1'b0};
    vecs[8]  = '{1'b0, 1'b0, 20, 0, 0, 0, 1'b0, 1'b0, 1'b0};
    vecs[9]  = '{1'b1, 1'b0, 24, 1, 0, 0, 1'b1, 1'b1, 1'b0};
    vecs[10] = '{1'b0, 1'b0, 20, 0, 0, 0, 1'b0, 1'b1, 1'b0};
    vecs[11] = '{1'b0, 1'b1, 20, 0, 1, 0, 1'b0, 1'b0, 1'b0};
    vecs[12] = '{1'b0, 1'b0, 20, 0, 0, 0, 1'b0, 1'b0, 1'b0};
    vecs[13] = '{1'b1, 1'b1, 20, 1, 1, 1, 1'b1, 1'b1, 1'b0};

    // Reset with keys released
    rst = 1'b0;
    drive_keys(1'b0, 1'b0);
    repeat (5) @(posedge clk);
    #1;
    check("rst_pause", int'(key_if.pause), 1);
    check("rst_clr", int'(key_if.clr), 0);
    check("rst_clr_pulse", int'(key_if.clr_pulse), 0);
    check("rst_pause_pulse", int'(key_if.pause_pulse), 0);
    @(negedge clk);
    rst = 1'b1;

    // Table-driven windows: each is long enough for a change at its start to settle
    for (int v = 0; v < 14; v++) begin
      @(negedge clk);
      drive_keys(vecs[v].clr_key, vecs[v].pause_key);
      cp_rise = 0; pp_rise = 0; cp_high = 0; pp_high = 0; both = 0;
      for (int c = 0; c < vecs[v].cycles; c++) begin
        @(posedge clk);
        #1;
        if (key_if.clr_pulse) cp_high++;
        if (key_if.pause_pulse) pp_high++;
        if (key_if.clr_pulse && !prev_cp) cp_rise++;
        if (key_if.pause_pulse && !prev_pp) pp_rise++;
        if (key_if.clr_pulse && key_if.pause_pulse) both++;
        prev_cp = key_if.clr_pulse;
        prev_pp = key_if.pause_pulse;
      end
      check($sformatf("v%0d_clr_pulses", v), cp_rise, vecs[v].exp_clr_pulses);
      check($sformatf("v%0d_clr_pulse_width", v), cp_high, vecs[v].exp_clr_pulses);
      check($sformatf("v%0d_pause_pulses", v), pp_rise, vecs[v].exp_pause_pulses);
      check($sformatf("v%0d_pause_pulse_width", v), pp_high, vecs[v].exp_pause_pulses);
      check($sformatf("v%0d_same_cycle", v), both, vecs[v].exp_both);
      check($sformatf("v%0d_clr", v), int'(key_if.clr), int'(vecs[v].exp_clr));
      check($sformatf("v%0d_pause", v), int'(key_if.pause), int'(vecs[v].exp_pause));
      if (vecs[v].chk_cnt) begin
        check($sformatf("v%0d_pause_cnt", v), int'(dut.r_cnt[1]), 0);
      end
    end

    // Release clear so the final state is STOP with keys idle
    @(negedge clk);
    drive_keys(1'b0, 1'b0);
    repeat (20) @(posedge clk);
    #1;
    check("idle_clr", int'(key_if.clr), 0);
    check("idle_pause", int'(key_if.pause), 1);

    // Reset in the middle of a pause press, key held through reset release
    @(negedge clk);
    drive_keys(1'b0, 1'b1);
    repeat (8) @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    check("midrst_cnt", int'(dut.r_cnt[1]), 0);
    check("midrst_pause", int'(key_if.pause), 1);
    check("midrst_pulse", int'(key_if.pause_pulse), 0);
    rst = 1'b1;
    pre_pulses = 0; total_pulses = 0;
    pulse13 = 1'b0; pause13 = 1'b0; pause14 = 1'b0; pulse14 = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk);
      #1;
      if (key_if.pause_pulse) total_pulses++;
      if (k <= 12 && key_if.pause_pulse) pre_pulses++;
      if (k == 13) begin
        pulse13 = key_if.pause_pulse;
        pause13 = key_if.pause;
      end
      if (k == 14) begin
        pause14 = key_if.pause;
        pulse14 = key_if.pause_pulse;
      end
    end
    check("hold_no_early_pulse", pre_pulses, 0);
    check("hold_pulse_at_13", int'(pulse13), 1);
    check("hold_pause_at_13", int'(pause13), 1);
    check("hold_pause_at_14", int'(pause14), 0);
    check("hold_pulse_at_14", int'(pulse14), 0);
    check("hold_total_pulses", total_pulses, 1);
    check("hold_final_pause", int'(key_if.pause), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
